// File: rtl/ctrl_unit.sv
// ctrl_unit: hardwired control sequencer for the 32-bit bus datapath.
// Each instruction starts with a three-step fetch (T0-T2). IR[31:27] is then
// decoded and steps T3..T7 run for the instruction class. Memory steps stall
// on mem_ready. A step that stalls for MEM_WAIT_MAX cycles sets a sticky error
// and halts the sequencer. Every output is a Moore decode of state and IR.
module ctrl_unit #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    // bus drive selects
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    // register load enables
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Rin,
    // IR register-field selects
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    // PC increment and memory strobes
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    // ALU operation, one-hot, only together with Zin
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    // status
    output logic        clear,
    output logic        run,
    output logic        err
);

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    // Instruction classes. Opcodes that are not defined decode as CLS_NOP.
    typedef enum logic [2:0] {
        CLS_LD,
        CLS_LDI,
        CLS_ST,
        CLS_ALU,
        CLS_ALUI,
        CLS_UN,
        CLS_NOP,
        CLS_HALT
    } cls_t;

    // ALU op vector bit order: {ADD,SUB,AND,OR,SHR,SHL,ROR,ROL,NEG,NOT}
    localparam logic [9:0] OP_ADD = 10'b10_0000_0000;
    localparam logic [9:0] OP_SUB = 10'b01_0000_0000;
    localparam logic [9:0] OP_AND = 10'b00_1000_0000;
    localparam logic [9:0] OP_OR  = 10'b00_0100_0000;
    localparam logic [9:0] OP_SHR = 10'b00_0010_0000;
    localparam logic [9:0] OP_SHL = 10'b00_0001_0000;
    localparam logic [9:0] OP_ROR = 10'b00_0000_1000;
    localparam logic [9:0] OP_ROL = 10'b00_0000_0100;
    localparam logic [9:0] OP_NEG = 10'b00_0000_0010;
    localparam logic [9:0] OP_NOT = 10'b00_0000_0001;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    cls_t       cls;
    logic [9:0] alu_vec;
    logic       alu_en;
    logic       wait_st;
    state_t     adv_state;
    logic [4:0] opcode;
    logic       ir_unused;

    assign opcode    = IR[31:27];
    // The register and constant fields are consumed by the datapath, not here.
    assign ir_unused = ^IR[26:0];

    // Opcode decode: instruction class plus the ALU op the class uses.
    always_comb begin
        cls     = CLS_NOP;
        alu_vec = '0;
        case (opcode)
            5'b00000: begin cls = CLS_LD;   alu_vec = OP_ADD; end
            5'b00001: begin cls = CLS_LDI;  alu_vec = OP_ADD; end
            5'b00010: begin cls = CLS_ST;   alu_vec = OP_ADD; end
            5'b00011: begin cls = CLS_ALU;  alu_vec = OP_ADD; end
            5'b00100: begin cls = CLS_ALU;  alu_vec = OP_SUB; end
            5'b00101: begin cls = CLS_ALU;  alu_vec = OP_AND; end
            5'b00110: begin cls = CLS_ALU;  alu_vec = OP_OR;  end
            5'b00111: begin cls = CLS_ALU;  alu_vec = OP_SHR; end
            5'b01000: begin cls = CLS_ALU;  alu_vec = OP_SHL; end
            5'b01001: begin cls = CLS_ALU;  alu_vec = OP_ROR; end
            5'b01010: begin cls = CLS_ALU;  alu_vec = OP_ROL; end
            5'b01011: begin cls = CLS_ALUI; alu_vec = OP_ADD; end
            5'b01100: begin cls = CLS_ALUI; alu_vec = OP_AND; end
            5'b01101: begin cls = CLS_ALUI; alu_vec = OP_OR;  end
            5'b01110: begin cls = CLS_UN;   alu_vec = OP_NEG; end
            5'b01111: begin cls = CLS_UN;   alu_vec = OP_NOT; end
            5'b11001: begin cls = CLS_HALT; end
            default:  begin cls = CLS_NOP;  end
        endcase
    end

    // Step that follows the current one when no memory stall is pending.
    // The T2 branch needs the opcode so nop and halt can skip T3 entirely.
    always_comb begin
        adv_state = state_q;
        wait_st   = 1'b0;
        case (state_q)
            S_RST: adv_state = S_T0;
            S_T0:  adv_state = S_T1;
            S_T1: begin
                adv_state = S_T2;
                wait_st   = 1'b1;
            end
            S_T2: begin
                if (cls == CLS_HALT) begin
                    adv_state = S_HALT;
                end else if (cls == CLS_NOP) begin
                    adv_state = S_T0;
                end else begin
                    adv_state = S_T3;
                end
            end
            S_T3:  adv_state = S_T4;
            S_T4:  adv_state = (cls == CLS_UN) ? S_T0 : S_T5;
            S_T5:  adv_state = (cls == CLS_LD || cls == CLS_ST) ? S_T6 : S_T0;
            S_T6: begin
                adv_state = S_T7;
                wait_st   = (cls == CLS_LD);
            end
            S_T7: begin
                adv_state = S_T0;
                wait_st   = (cls == CLS_ST);
            end
            S_HALT: adv_state = S_HALT;
            default: adv_state = S_HALT;
        endcase
    end

    // Memory handshake: hold a wait step until mem_ready, counting stalled
    // cycles; the last permitted stall ends in an error halt instead.
    always_comb begin
        state_d = adv_state;
        cnt_d   = '0;
        err_d   = err_q;
        if (wait_st && !mem_ready) begin
            if (cnt_q == WAIT_LAST) begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end else begin
                state_d = state_q;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // State, stall counter and sticky error; clear_n aborts at once.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Control word for the current step; ALU op lines come from the decode.
    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Cout    = 1'b0;
        BAout   = 1'b0;
        Rout    = 1'b0;
        PCin    = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Rin     = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        alu_en  = 1'b0;
        clear   = (state_q == S_RST);
        run     = (state_q != S_RST) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                    CLS_ALU, CLS_ALUI: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    CLS_UN: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CLS_LD, CLS_LDI, CLS_ST, CLS_ALUI: begin
                        Cout = 1'b1; Zin = 1'b1; alu_en = 1'b1;
                    end
                    CLS_ALU: begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en = 1'b1;
                    end
                    CLS_UN: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CLS_LD, CLS_ST: begin
                        Zlowout = 1'b1; MARin = 1'b1;
                    end
                    CLS_LDI, CLS_ALU, CLS_ALUI: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CLS_LD: begin
                        Read = 1'b1; MDRin = 1'b1;
                    end
                    CLS_ST: begin
                        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CLS_LD: begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    CLS_ST: begin
                        Write = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // ALU op lines are quiet unless the current step loads Z.
    assign {ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT} = alu_en ? alu_vec : 10'b0;

    assign err = err_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: directed bench for ctrl_unit. The stimulus process queues the
// expected control word for every cycle it drives. A monitor samples the DUT
// on the falling edge, pops the queue and compares, and checks bus and ALU
// exclusivity on every cycle.
module tb_ctrl_unit;

    logic        clk;
    logic        clear_n;
    logic [31:0] IR;
    logic        mem_ready;
    logic PCout, Zlowout, MDRout, Cout, BAout, Rout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, Rin;
    logic Gra, Grb, Grc, IncPC, Read, Write;
    logic ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT;
    logic clear, run, err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    // Observed word bit positions
    localparam logic [31:0] B_PCOUT   = 32'd1 << 31;
    localparam logic [31:0] B_ZLOWOUT = 32'd1 << 30;
    localparam logic [31:0] B_MDROUT  = 32'd1 << 29;
    localparam logic [31:0] B_COUT    = 32'd1 << 28;
    localparam logic [31:0] B_BAOUT   = 32'd1 << 27;
    localparam logic [31:0] B_ROUT    = 32'd1 << 26;
    localparam logic [31:0] B_PCIN    = 32'd1 << 25;
    localparam logic [31:0] B_MARIN   = 32'd1 << 24;
    localparam logic [31:0] B_MDRIN   = 32'd1 << 23;
    localparam logic [31:0] B_IRIN    = 32'd1 << 22;
    localparam logic [31:0] B_YIN     = 32'd1 << 21;
    localparam logic [31:0] B_ZIN     = 32'd1 << 20;
    localparam logic [31:0] B_RIN     = 32'd1 << 19;
    localparam logic [31:0] B_GRA     = 32'd1 << 18;
    localparam logic [31:0] B_GRB     = 32'd1 << 17;
    localparam logic [31:0] B_GRC     = 32'd1 << 16;
    localparam logic [31:0] B_INCPC   = 32'd1 << 15;
    localparam logic [31:0] B_READ    = 32'd1 << 14;
    localparam logic [31:0] B_WRITE   = 32'd1 << 13;
    localparam logic [31:0] B_ADD     = 32'd1 << 12;
    localparam logic [31:0] B_SUB     = 32'd1 << 11;
    localparam logic [31:0] B_AND     = 32'd1 << 10;
    localparam logic [31:0] B_OR      = 32'd1 << 9;
    localparam logic [31:0] B_SHR     = 32'd1 << 8;
    localparam logic [31:0] B_NOT     = 32'd1 << 3;
    localparam logic [31:0] B_CLEAR   = 32'd1 << 2;
    localparam logic [31:0] B_RUN     = 32'd1 << 1;
    localparam logic [31:0] B_ERR     = 32'd1 << 0;

    // Hand-built expected words per step
    localparam logic [31:0] E_RST  = B_CLEAR;
    localparam logic [31:0] E_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
    localparam logic [31:0] E_T1   = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_RUN;
    localparam logic [31:0] E_T2   = B_MDROUT | B_IRIN | B_RUN;
    localparam logic [31:0] E_LD3  = B_GRB | B_BAOUT | B_YIN | B_RUN;
    localparam logic [31:0] E_LD4  = B_COUT | B_ADD | B_ZIN | B_RUN;
    localparam logic [31:0] E_LD5  = B_ZLOWOUT | B_MARIN | B_RUN;
    localparam logic [31:0] E_LD6  = B_READ | B_MDRIN | B_RUN;
    localparam logic [31:0] E_LD7  = B_MDROUT | B_GRA | B_RIN | B_RUN;
    localparam logic [31:0] E_ST6  = B_GRA | B_ROUT | B_MDRIN | B_RUN;
    localparam logic [31:0] E_ST7  = B_WRITE | B_RUN;
    localparam logic [31:0] E_R3   = B_GRB | B_ROUT | B_YIN | B_RUN;
    localparam logic [31:0] E_WB   = B_ZLOWOUT | B_GRA | B_RIN | B_RUN;
    localparam logic [31:0] E_ALU4 = B_GRC | B_ROUT | B_ZIN | B_RUN;
    localparam logic [31:0] E_IMM4 = B_COUT | B_ZIN | B_RUN;

    ctrl_unit #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut (
        .clk(clk), .clear_n(clear_n), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
        .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
        .clear(clear), .run(run), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: per-cycle scoreboard compare plus exclusivity checks.
    always @(negedge clk) begin
        logic [31:0] obs;
        logic [31:0] e;
        string       nm;
        obs = {PCout, Zlowout, MDRout, Cout, BAout, Rout, PCin, MARin, MDRin, IRin,
               Yin, Zin, Rin, Gra, Grb, Grc, IncPC, Read, Write,
               ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT, clear, run, err};
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s: got %h required %h (diff %h)", nm, obs, e, obs ^ e);
            end else begin
                $display("ok   %s: %h", nm, obs);
            end
        end
        n_checks++;
        if ($countones({PCout, Zlowout, MDRout, Cout, BAout, Rout}) > 1) begin
            n_fail++;
            $display("FAIL bus_onehot: got %b required at most one", {PCout, Zlowout, MDRout, Cout, BAout, Rout});
        end
        n_checks++;
        if ($countones({ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT}) > 1 ||
            (({ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT} != 10'b0) && !Zin)) begin
            n_fail++;
            $display("FAIL alu_onehot: got %b zin %b required at most one with Zin",
                     {ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT}, Zin);
        end
        n_checks++;
        if (Read && Write) begin
            n_fail++;
            $display("FAIL read_write: got both high required not both");
        end
    end

    // Describe the current cycle, set mem_ready for its closing edge, advance.
    task automatic cyc(input logic [31:0] e, input string nm, input logic rdy);
        mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string nm);
        cyc(E_T0, {nm, "_T0"}, 1'b1);
        cyc(E_T1, {nm, "_T1"}, 1'b1);
        cyc(E_T2, {nm, "_T2"}, 1'b1);
    endtask

    task automatic do_reset(input string nm);
        clear_n = 1'b0;
        #1;
        cyc(E_RST, {nm, "_asserted"}, 1'b0);
        clear_n = 1'b1;
        cyc(E_RST, {nm, "_released"}, 1'b0);
    endtask

    initial begin
        clear_n   = 1'b0;
        IR        = 32'h0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset");

        // ld with no stall: eight steps, write-back in T7, then T0
        IR = 32'h0100_0085;
        fetch("ld");
        cyc(E_LD3, "ld_T3", 1'b1);
        cyc(E_LD4, "ld_T4", 1'b1);
        cyc(E_LD5, "ld_T5", 1'b1);
        cyc(E_LD6, "ld_T6", 1'b1);
        cyc(E_LD7, "ld_T7", 1'b1);

        // add: six cycles
        IR = 32'h1800_0000;
        fetch("add");
        cyc(E_R3, "add_T3", 1'b1);
        cyc(E_ALU4 | B_ADD, "add_T4", 1'b1);
        cyc(E_WB, "add_T5", 1'b1);

        // shr and andi/addi exercise the op select
        IR = 32'h3800_0000;
        fetch("shr");
        cyc(E_R3, "shr_T3", 1'b1);
        cyc(E_ALU4 | B_SHR, "shr_T4", 1'b1);
        cyc(E_WB, "shr_T5", 1'b1);
        IR = 32'h6000_0000;
        fetch("andi");
        cyc(E_R3, "andi_T3", 1'b1);
        cyc(E_IMM4 | B_AND, "andi_T4", 1'b1);
        cyc(E_WB, "andi_T5", 1'b1);

        // not: two execute steps
        IR = 32'h7800_0000;
        fetch("not");
        cyc(E_R3 & ~B_YIN | B_ZIN | B_NOT, "not_T3", 1'b1);
        cyc(E_WB, "not_T4", 1'b1);

        // ldi: write-back in T5
        IR = 32'h0800_0000;
        fetch("ldi");
        cyc(E_LD3, "ldi_T3", 1'b1);
        cyc(E_LD4, "ldi_T4", 1'b1);
        cyc(E_WB, "ldi_T5", 1'b1);

        // st with two stalled cycles in the write step
        IR = 32'h1000_0000;
        fetch("st");
        cyc(E_LD3, "st_T3", 1'b1);
        cyc(E_LD4, "st_T4", 1'b1);
        cyc(E_LD5, "st_T5", 1'b1);
        cyc(E_ST6, "st_T6", 1'b0);
        cyc(E_ST7, "st_T7_stall", 1'b0);
        cyc(E_ST7, "st_T7_stall", 1'b0);
        cyc(E_ST7, "st_T7_ready", 1'b1);

        // ld with three stalled fetch cycles: T1 held four cycles
        IR = 32'h0100_0085;
        cyc(E_T0, "stall_T0", 1'b0);
        repeat (3) cyc(E_T1, "stall_T1_wait", 1'b0);
        cyc(E_T1, "stall_T1_ready", 1'b1);
        cyc(E_T2, "stall_T2", 1'b0);
        cyc(E_LD3, "stall_T3", 1'b0);
        cyc(E_LD4, "stall_T4", 1'b0);
        cyc(E_LD5, "stall_T5", 1'b0);
        cyc(E_LD6, "stall_T6", 1'b1);
        cyc(E_LD7, "stall_T7", 1'b0);

        // 14 stalls is the last count that still completes
        IR = 32'hC000_0000;
        cyc(E_T0, "edge14_T0", 1'b1);
        repeat (14) cyc(E_T1, "edge14_T1_wait", 1'b0);
        cyc(E_T1, "edge14_T1_ready", 1'b1);
        cyc(E_T2, "edge14_T2", 1'b1);

        // illegal opcode behaves as nop: T2 then T0
        IR = 32'hA800_0000;
        fetch("illegal");

        // timeout: ld never completes its data read
        IR = 32'h0100_0085;
        fetch("tmo");
        cyc(E_LD3, "tmo_T3", 1'b1);
        cyc(E_LD4, "tmo_T4", 1'b1);
        cyc(E_LD5, "tmo_T5", 1'b1);
        repeat (15) cyc(E_LD6, "tmo_T6_wait", 1'b0);
        cyc(B_ERR, "tmo_halt", 1'b1);
        cyc(B_ERR, "tmo_halt_hold", 1'b0);
        do_reset("tmo_reset");

        // halt opcode: run falls after T2 and stays low
        IR = 32'hC800_0000;
        fetch("halt");
        cyc(32'h0, "halt_S_HALT", 1'b1);
        cyc(32'h0, "halt_hold", 1'b1);
        do_reset("halt_reset");

        // reset asserted in T4 of sub aborts within the same cycle
        IR = 32'h2000_0000;
        fetch("sub");
        cyc(E_R3, "sub_T3", 1'b1);
        exp_q.push_back(E_RST);
        name_q.push_back("sub_T4_abort");
        #1;
        clear_n = 1'b0;
        @(posedge clk);
        #1;
        clear_n = 1'b1;
        cyc(E_RST, "sub_abort_release", 1'b1);
        cyc(E_T0, "resume_T0", 1'b1);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
